// File: rtl/firewall_rule_engine.sv
// firewall_rule_engine: latches parsed IPv4 header fields on the parser's
// frame-done strobe, scans a programmable rule table one entry per cycle and
// issues a permit/drop verdict from the first matching rule (or a default).
module firewall_rule_engine #(
  parameter int NUM_RULES      = 8,
  parameter int RULE_AW        = 3,
  parameter bit DEFAULT_PERMIT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  input  logic [31:0]        srcip4,
  input  logic [31:0]        dstip4,
  input  logic [7:0]         Ipproto,
  input  logic [15:0]        Dstport,
  input  logic               cfg_we,
  input  logic [RULE_AW-1:0] cfg_addr,
  input  logic [2:0]         cfg_sel,
  input  logic [31:0]        cfg_wdata,
  output logic               busy,
  output logic               decision_valid,
  output logic               permit,
  output logic               rule_hit,
  output logic [RULE_AW-1:0] hit_index,
  output logic [7:0]         miss_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Rule table storage, one set of words per entry
  logic [31:0] src_ip_q   [NUM_RULES];
  logic [31:0] src_mask_q [NUM_RULES];
  logic [31:0] dst_ip_q   [NUM_RULES];
  logic [31:0] dst_mask_q [NUM_RULES];
  logic        valid_q    [NUM_RULES];
  logic        action_q   [NUM_RULES];
  logic        proto_en_q [NUM_RULES];
  logic [7:0]  proto_q    [NUM_RULES];
  logic [15:0] port_lo_q  [NUM_RULES];
  logic [15:0] port_hi_q  [NUM_RULES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RULES; gi++) begin : g_rule
      logic wr_en;
      // Addresses beyond the table never match any entry, so they are dropped
      assign wr_en = cfg_we && (cfg_addr == RULE_AW'(gi));

      // Host write port: commits one word of this entry at the clock edge
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          src_ip_q[gi]   <= '0;
          src_mask_q[gi] <= '0;
          dst_ip_q[gi]   <= '0;
          dst_mask_q[gi] <= '0;
          valid_q[gi]    <= 1'b0;
          action_q[gi]   <= 1'b0;
          proto_en_q[gi] <= 1'b0;
          proto_q[gi]    <= '0;
          port_lo_q[gi]  <= '0;
          port_hi_q[gi]  <= '0;
        end else if (wr_en) begin
          case (cfg_sel)
            3'd0: src_ip_q[gi]   <= cfg_wdata;
            3'd1: src_mask_q[gi] <= cfg_wdata;
            3'd2: dst_ip_q[gi]   <= cfg_wdata;
            3'd3: dst_mask_q[gi] <= cfg_wdata;
            3'd4: begin
              valid_q[gi]    <= cfg_wdata[0];
              action_q[gi]   <= cfg_wdata[1];
              proto_en_q[gi] <= cfg_wdata[2];
              proto_q[gi]    <= cfg_wdata[15:8];
            end
            3'd5: begin
              port_lo_q[gi] <= cfg_wdata[15:0];
              port_hi_q[gi] <= cfg_wdata[31:16];
            end
            default: ;
          endcase
        end
      end
    end
  endgenerate

  state_t             state_q, state_d;
  logic [RULE_AW-1:0] idx_q, idx_d;
  logic [31:0]        sh_src_q, sh_src_d, sh_dst_q, sh_dst_d;
  logic [7:0]         sh_proto_q, sh_proto_d;
  logic [15:0]        sh_port_q, sh_port_d;
  logic               permit_q, permit_d, rule_hit_q, rule_hit_d;
  logic [RULE_AW-1:0] hit_index_q, hit_index_d;
  logic [7:0]         miss_cnt_q, miss_cnt_d;
  logic               rule_match;

  // Evaluate the current rule against the shadow fields; table reads see the
  // pre-write value, so a same-cycle config write cannot disturb this result
  always_comb begin
    rule_match = valid_q[idx_q]
      && (((sh_src_q ^ src_ip_q[idx_q]) & src_mask_q[idx_q]) == 32'd0)
      && (((sh_dst_q ^ dst_ip_q[idx_q]) & dst_mask_q[idx_q]) == 32'd0)
      && (!proto_en_q[idx_q] || (proto_q[idx_q] == sh_proto_q))
      && (port_lo_q[idx_q] <= sh_port_q)
      && (sh_port_q <= port_hi_q[idx_q]);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sh_src_q    <= '0;
      sh_dst_q    <= '0;
      sh_proto_q  <= '0;
      sh_port_q   <= '0;
      permit_q    <= 1'b0;
      rule_hit_q  <= 1'b0;
      hit_index_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sh_src_q    <= sh_src_d;
      sh_dst_q    <= sh_dst_d;
      sh_proto_q  <= sh_proto_d;
      sh_port_q   <= sh_port_d;
      permit_q    <= permit_d;
      rule_hit_q  <= rule_hit_d;
      hit_index_q <= hit_index_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Next-state and verdict recording; new frames are accepted only in IDLE
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sh_src_d    = sh_src_q;
    sh_dst_d    = sh_dst_q;
    sh_proto_d  = sh_proto_q;
    sh_port_d   = sh_port_q;
    permit_d    = permit_q;
    rule_hit_d  = rule_hit_q;
    hit_index_d = hit_index_q;
    miss_cnt_d  = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (ready) begin
          sh_src_d   = srcip4;
          sh_dst_d   = dstip4;
          sh_proto_d = Ipproto;
          sh_port_d  = Dstport;
          idx_d      = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (rule_match) begin
          permit_d    = action_q[idx_q];
          rule_hit_d  = 1'b1;
          hit_index_d = idx_q;
          state_d     = DONE;
        end else if (idx_q == RULE_AW'(NUM_RULES - 1)) begin
          permit_d    = DEFAULT_PERMIT;
          rule_hit_d  = 1'b0;
          hit_index_d = '0;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Frames arriving while the engine is occupied are counted, not queued
    if (ready && (state_q != IDLE) && (miss_cnt_q != 8'hFF))
      miss_cnt_d = miss_cnt_q + 8'd1;
  end

  // Output decode
  always_comb begin
    busy           = (state_q != IDLE);
    decision_valid = (state_q == DONE);
    permit         = permit_q;
    rule_hit       = rule_hit_q;
    hit_index      = hit_index_q;
    miss_cnt       = miss_cnt_q;
  end

endmodule

// File: tb/tb_firewall_rule_engine.sv
// Testbench for firewall_rule_engine: directed frames with a verdict
// scoreboard checked by an independent monitor on the falling edge.
module tb_firewall_rule_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] srcip4 = '0, dstip4 = '0;
  logic [7:0]  Ipproto = '0;
  logic [15:0] Dstport = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [2:0]  cfg_sel = '0;
  logic [31:0] cfg_wdata = '0;
  logic        busy, decision_valid, permit, rule_hit;
  logic [2:0]  hit_index;
  logic [7:0]  miss_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int txn = 0;

  typedef struct {
    logic       p;
    logic       h;
    logic [2:0] idx;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  firewall_rule_engine #(.NUM_RULES(8), .RULE_AW(3), .DEFAULT_PERMIT(1'b0)) dut (
    .clk(clk), .reset(reset), .ready(ready), .srcip4(srcip4), .dstip4(dstip4),
    .Ipproto(Ipproto), .Dstport(Dstport), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .busy(busy),
    .decision_valid(decision_valid), .permit(permit), .rule_hit(rule_hit),
    .hit_index(hit_index), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every verdict strobe must match the oldest expected verdict
  always @(negedge clk) begin
    if (decision_valid) begin
      txn++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_decision: got strobe at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %0d: cycle=%0d permit=%0b rule_hit=%0b hit_index=%0d", txn, cyc,
                 permit, rule_hit, hit_index);
        chk("permit", {31'd0, permit}, {31'd0, e.p});
        chk("rule_hit", {31'd0, rule_hit}, {31'd0, e.h});
        chk("hit_index", {29'd0, hit_index}, {29'd0, e.idx});
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int sel, input logic [31:0] data);
    cfg_we = 1'b1; cfg_addr = addr[2:0]; cfg_sel = sel[2:0]; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  // Issue a one-cycle ready; when push is set, queue the verdict due `lat`
  // cycles after the ready cycle
  task automatic frame(input logic [31:0] s, input logic [31:0] d, input logic [7:0] pr,
                       input logic [15:0] port, input bit push, input logic ep,
                       input logic eh, input logic [2:0] ei, input int lat);
    exp_t e;
    srcip4 = s; dstip4 = d; Ipproto = pr; Dstport = port;
    ready = 1'b1;
    if (push) begin
      e.p = ep; e.h = eh; e.idx = ei; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    tick();
    ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles expected 0", busy, n);
    end
    tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_decision_valid", {31'd0, decision_valid}, 32'd0);
    chk("rst_permit", {31'd0, permit}, 32'd0);
    chk("rst_rule_hit", {31'd0, rule_hit}, 32'd0);
    chk("rst_hit_index", {29'd0, hit_index}, 32'd0);
    chk("rst_miss_cnt", {24'd0, miss_cnt}, 32'd0);
    reset = 1'b1;
    tick();

    // Empty table: default verdict after full scan (T+9)
    frame(32'h0A010203, 32'hC0A80001, 8'd6, 16'd80, 1, 1'b0, 1'b0, 3'd0, 9);
    wait_idle();

    // Rule 2: src 10/8, proto 6, port 80..80, permit
    cfg_write(2, 0, 32'h0A000000);
    cfg_write(2, 1, 32'hFF000000);
    cfg_write(2, 4, 32'h00000607);
    cfg_write(2, 5, 32'h00500050);
    frame(32'h0A010203, 32'hC0A80001, 8'd6, 16'd80, 1, 1'b1, 1'b1, 3'd2, 4);
    wait_idle();
    // Protocol mismatch on rule 2 -> default
    frame(32'h0A010203, 32'hC0A80001, 8'd17, 16'd80, 1, 1'b0, 1'b0, 3'd0, 9);
    wait_idle();

    // Rule 0: drop anything to port 80 -> wins by priority
    cfg_write(0, 4, 32'h00000001);
    cfg_write(0, 5, 32'h00500050);
    frame(32'h0A010203, 32'hC0A80001, 8'd6, 16'd80, 1, 1'b0, 1'b1, 3'd0, 2);
    wait_idle();
    frame(32'h0A010203, 32'hC0A80001, 8'd6, 16'd81, 1, 1'b0, 1'b0, 3'd0, 9);
    wait_idle();

    // Second ready 3 cycles into a scan is dropped and counted
    frame(32'h0A010203, 32'hC0A80001, 8'd6, 16'd81, 1, 1'b0, 1'b0, 3'd0, 9);
    tick();
    frame(32'h0A010203, 32'hC0A80001, 8'd6, 16'd80, 0, 1'b0, 1'b0, 3'd0, 0);
    wait_idle();
    chk("miss_cnt_one", {24'd0, miss_cnt}, 32'd1);

    // Flood ready while busy: 8 drops per frame, saturating at 255
    for (int f = 0; f < 38; f++) begin
      frame(32'h0A010203, 32'hC0A80001, 8'd6, 16'd81, 1, 1'b0, 1'b0, 3'd0, 9);
      ready = 1'b1;
      repeat (8) tick();
      ready = 1'b0;
      wait_idle();
      if (f == 30) chk("miss_cnt_249", {24'd0, miss_cnt}, 32'd249);
    end
    chk("miss_cnt_sat", {24'd0, miss_cnt}, 32'd255);

    // Rule 1 with lo>hi never matches; rule 3 (70..80) catches port 75
    cfg_write(1, 4, 32'h00000003);
    cfg_write(1, 5, 32'h00320064);
    cfg_write(3, 4, 32'h00000003);
    cfg_write(3, 5, 32'h00500046);
    frame(32'h01020304, 32'h05060708, 8'd17, 16'd75, 1, 1'b1, 1'b1, 3'd3, 5);
    wait_idle();

    // Reset during SCAN at idx=4: no verdict, outputs cleared at once
    frame(32'h01020304, 32'h05060708, 8'd17, 16'd81, 0, 1'b0, 1'b0, 3'd0, 0);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_permit", {31'd0, permit}, 32'd0);
    chk("abort_rule_hit", {31'd0, rule_hit}, 32'd0);
    chk("abort_miss_cnt", {24'd0, miss_cnt}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    // Table cleared: the packet rule 3 used to permit now gets the default
    frame(32'h01020304, 32'h05060708, 8'd17, 16'd75, 1, 1'b0, 1'b0, 3'd0, 9);
    wait_idle();

    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
